// File: rtl/pet2001_kbd_pkg.sv
// pet2001_kbd_pkg: shared constants, types and keymap helper for the PS/2 to PET keyboard bridge
package pet2001_kbd_pkg;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam int unsigned PET_ROWS  = 10;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_t;
  function automatic key_t k(input logic [3:0] r, input logic [2:0] c);
    return '{valid: 1'b1, row: r, col: c};
  endfunction
endpackage

// File: rtl/pet2001_ps2_keymap.sv
// pet2001_ps2_keymap: combinational ROM from {ext, set-2 scancode} to PET matrix position
module pet2001_ps2_keymap
  import pet2001_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_t       key
);
  // table lookup; codes not listed (e.g. E0 75) stay unmapped
  always_comb begin
    key = '0;
    case ({ext, code})
      9'h16C: key = k(0, 6);  9'h174: key = k(0, 7);
      9'h172: key = k(1, 6);  9'h171: key = k(1, 7);  9'h066: key = k(1, 7);
      9'h015: key = k(2, 0);  9'h024: key = k(2, 1);  9'h02C: key = k(2, 2);  9'h03C: key = k(2, 3);
      9'h044: key = k(2, 4);  9'h03D: key = k(2, 6);  9'h046: key = k(2, 7);
      9'h01D: key = k(3, 0);  9'h02D: key = k(3, 1);  9'h035: key = k(3, 2);  9'h043: key = k(3, 3);
      9'h04D: key = k(3, 4);  9'h03E: key = k(3, 6);  9'h04A: key = k(3, 7);
      9'h01C: key = k(4, 0);  9'h023: key = k(4, 1);  9'h034: key = k(4, 2);  9'h03B: key = k(4, 3);
      9'h04B: key = k(4, 4);  9'h025: key = k(4, 6);  9'h036: key = k(4, 7);
      9'h01B: key = k(5, 0);  9'h02B: key = k(5, 1);  9'h033: key = k(5, 2);  9'h042: key = k(5, 3);
      9'h02E: key = k(5, 6);
      9'h01A: key = k(6, 0);  9'h021: key = k(6, 1);  9'h032: key = k(6, 2);  9'h03A: key = k(6, 3);
      9'h04C: key = k(6, 4);  9'h05A: key = k(6, 5);  9'h15A: key = k(6, 5);  9'h016: key = k(6, 6);
      9'h026: key = k(6, 7);
      9'h022: key = k(7, 0);  9'h02A: key = k(7, 1);  9'h031: key = k(7, 2);  9'h041: key = k(7, 3);
      9'h01E: key = k(7, 6);
      9'h012: key = k(8, 0);  9'h05B: key = k(8, 2);  9'h059: key = k(8, 5);  9'h045: key = k(8, 6);
      9'h04E: key = k(8, 7);
      9'h054: key = k(9, 1);  9'h029: key = k(9, 2);  9'h076: key = k(9, 4);  9'h049: key = k(9, 6);
      9'h055: key = k(9, 7);
      default: key = '0;
    endcase
  end
endmodule

// File: rtl/pet2001_ps2_kbd.sv
// pet2001_ps2_kbd: PS/2 receiver and decoder driving a scanned PET 2001 10x8 key matrix
module pet2001_ps2_kbd
  import pet2001_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       kbd_event,
  output logic       ps2_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_s, dat_s;
  logic clk_d, fall, good, tmo, brk, ext;
  logic [9:0] sh;
  logic [3:0] bcnt;
  logic [CW-1:0] cnt;
  logic [7:0] code;
  logic [7:0] matrix [PET_ROWS];
  rx_state_t st;
  key_t km;
  assign fall = clk_d & ~clk_s[1];
  assign code = sh[7:0];
  assign good = (^sh[8:0]) & sh[9];
  assign tmo = st == SHIFT && !fall && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign ps2_err = (st == IDLE && fall && dat_s[1]) || (st == CHECK && !good) || tmo;
  assign keyin = keyrow < 4'(PET_ROWS) ? ~matrix[keyrow] : 8'hFF;
  pet2001_ps2_keymap u_keymap (.ext(ext), .code(code), .key(km));
  // synchronise the PS/2 pins and keep the previous clock level for edge detection
  always_ff @(posedge clk) begin
    clk_s <= reset ? 2'b11 : {clk_s[0], ps2_clk};
    dat_s <= reset ? 2'b11 : {dat_s[0], ps2_data};
    clk_d <= reset ? 1'b1 : clk_s[1];
  end
  // frame receiver: start bit, 8 data LSB first, parity, stop, with an idle watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      bcnt <= '0;
      cnt <= '0;
      sh <= '0;
    end else begin
      case (st)
        IDLE: if (fall && !dat_s[1]) begin
          st <= SHIFT;
          bcnt <= '0;
          cnt <= '0;
        end
        SHIFT: if (fall) begin
          sh <= {dat_s[1], sh[9:1]};
          bcnt <= bcnt + 1'b1;
          cnt <= '0;
          if (bcnt == 4'd9) st <= CHECK;
        end else if (tmo) st <= IDLE;
        else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
  // decode the checked byte into prefix flags and matrix writes
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix <= '{default: '0};
      brk <= 1'b0;
      ext <= 1'b0;
      kbd_event <= 1'b0;
    end else begin
      kbd_event <= 1'b0;
      if (ps2_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (st == CHECK) begin
        if (code == PS2_BREAK) brk <= 1'b1;
        else if (code == PS2_EXT) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (code == PS2_BAT_OK) begin
            matrix <= '{default: '0};
            kbd_event <= 1'b1;
          end else if (km.valid && matrix[km.row][km.col] == brk) begin
            matrix[km.row][km.col] <= ~brk;
            kbd_event <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pet2001_ps2_kbd.sv
// tb_pet2001_ps2_kbd: directed self-checking bench for the PS/2 to PET keyboard bridge
module tb_pet2001_ps2_kbd;
  localparam int TMO = 100;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [3:0] keyrow = '0;
  logic [7:0] keyin;
  logic kbd_event, ps2_err;
  int checks = 0, failures = 0;
  int ev_total = 0, err_total = 0;
  int win_ev, win_err, ev_at, e0, r0;

  pet2001_ps2_kbd #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyrow(keyrow), .keyin(keyin), .kbd_event(kbd_event), .ps2_err(ps2_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kbd_event) ev_total++;
    if (ps2_err) err_total++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic row_is(input string tag, input logic [3:0] r, input logic [7:0] exp);
    keyrow = r;
    #1;
    chk(tag, {24'd0, keyin}, {24'd0, exp});
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (8) step();
    ps2_clk = 1'b0;
    repeat (8) step();
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    logic [9:0] f;
    f = {(~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (8) step();
    ps2_clk = 1'b0;
    win_ev = 0;
    win_err = 0;
    ev_at = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (kbd_event) begin
        win_ev++;
        if (ev_at == 0) ev_at = k;
      end
      if (ps2_err) win_err++;
    end
    ps2_clk = 1'b1;
    repeat (8) step();
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    logic [9:0] f;
    f = {~^b, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_event", {31'd0, kbd_event}, 32'd0);
    chk("rst_err", {31'd0, ps2_err}, 32'd0);
    for (int r = 0; r < 16; r += 3) row_is("rst_row", 4'(r), 8'hFF);
    reset = 1'b0;
    repeat (4) step();

    send(8'h1C, 1'b0);
    chk("a_make_ev_at", ev_at, 4);
    chk("a_make_ev_cnt", win_ev, 1);
    row_is("a_make_row4", 4'd4, 8'hFE);
    send(8'hF0, 1'b0);
    chk("brk_prefix_ev", win_ev, 0);
    send(8'h1C, 1'b0);
    chk("a_break_ev", win_ev, 1);
    chk("a_break_ev_at", ev_at, 4);
    row_is("a_break_row4", 4'd4, 8'hFF);

    send(8'h12, 1'b0);
    send(8'h59, 1'b0);
    row_is("shifts_row8", 4'd8, 8'hDE);
    row_is("unused_row12", 4'd12, 8'hFF);

    e0 = err_total;
    send(8'h1C, 1'b1);
    chk("par_err_win", win_err, 1);
    chk("par_err_ev", win_ev, 0);
    row_is("par_row4", 4'd4, 8'hFF);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    chk("par_err_total", err_total - e0, 2);
    row_is("par_prefix_cleared", 4'd4, 8'hFE);

    e0 = err_total;
    partial(8'h1C, 5);
    repeat (TMO + 10) step();
    chk("tmo_err", err_total - e0, 1);
    send(8'h5A, 1'b0);
    row_is("tmo_return_row6", 4'd6, 8'hDF);

    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    r0 = ev_total;
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    chk("typematic_ev", ev_total - r0, 1);
    r0 = ev_total;
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    chk("unmapped_ev", ev_total - r0, 0);
    row_is("unmapped_row4", 4'd4, 8'hFE);
    row_is("unmapped_row8", 4'd8, 8'hDE);
    row_is("unmapped_row0", 4'd0, 8'hFF);
    r0 = ev_total;
    send(8'hAA, 1'b0);
    chk("bat_ev", ev_total - r0, 1);
    for (int r = 0; r < 10; r++) row_is("bat_row", 4'(r), 8'hFF);

    send(8'h1C, 1'b0);
    row_is("pre_rst_row4", 4'd4, 8'hFE);
    send(8'hF0, 1'b0);
    e0 = err_total;
    partial(8'h1C, 6);
    reset = 1'b1;
    repeat (3) step();
    chk("midrst_event", {31'd0, kbd_event}, 32'd0);
    chk("midrst_err", {31'd0, ps2_err}, 32'd0);
    row_is("midrst_row4", 4'd4, 8'hFF);
    reset = 1'b0;
    repeat (4) step();
    send(8'h1C, 1'b0);
    chk("post_rst_ev", win_ev, 1);
    row_is("post_rst_make", 4'd4, 8'hFE);
    chk("midrst_no_err", err_total - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
